fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Controller that sequences the instruction fetch datapath. It generates the fetch PC, runs the request/acknowledge handshake to instruction memory, pushes returned words into the prefetch buffer, and tracks free buffer entries with credits. On a branch redirect it flushes the prefetch buffer, squashes any in-flight fetch and restarts at the target. It sits between the branch resolution/prediction logic and the prefetch buffer feeding decode.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
DEPTH, 4, prefetch buffer entries; initial and maximum credit count
CW, $clog2(DEPTH+1), credit counter width (derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
redirect_valid  in  1  redirect request (mispredict or predicted-taken branch)
redirect_pc  in  32  redirect target; bits [1:0] ignored, treated as 0
stall  in  1  decode stall; blocks new request issue only
pf_pop  in  1  consumer popped one prefetch buffer entry this cycle
imem_req  out  1  memory request, held high until acknowledged
imem_addr  out  32  request address, stable while imem_req=1
imem_ack  in  1  memory acknowledge; imem_rdata valid this cycle
imem_rdata  in  32  returned instruction word
pf_push  out  1  one-cycle push strobe to the prefetch buffer
pf_push_pc  out  32  PC of the pushed word
pf_push_data  out  32  pushed instruction word
pf_flush  out  1  one-cycle prefetch buffer clear
fetch_pc  out  32  next address to be requested
credits  out  CW  free entries not yet reserved
fetch_busy  out  1  high in REQ or SQUASH
perf_fetches  out  32  completed fetches (optional feature)
perf_squashes  out  32  squashed in-flight fetches (optional feature)
perf_stall_cycles  out  32  cycles where issue was blocked by stall or zero credits (optional feature)

Behaviour:
- All outputs are registered. Reset values: imem_req=0, imem_addr=RESET_PC, pf_push=0, pf_push_pc=0, pf_push_data=0, pf_flush=0, fetch_pc=RESET_PC, credits=DEPTH, fetch_busy=0, perf counters=0. State=IDLE.
- An assertion of rst at any time returns every output to its reset value immediately. An in-flight memory request is abandoned.
- States:
  - IDLE: move to ISSUE on the first clock after reset release. No request is issued.
  - ISSUE: if redirect_valid, load fetch_pc=redirect_pc, pulse pf_flush and stay in ISSUE. Else if credits>0 and !stall, set imem_req=1, set imem_addr=fetch_pc, decrement credits and go to REQ. Else stay in ISSUE.
  - REQ: imem_req stays high with imem_addr held.
    - On imem_ack without redirect: pf_push=1 next cycle with pf_push_pc=imem_addr and pf_push_data=imem_rdata; fetch_pc+=4.
    - If another issue is allowed in the same cycle (credits after update >0, !stall), stay in REQ with the new address. This gives back-to-back fetches at one word per cycle. Otherwise drop imem_req and go to ISSUE.
    - On redirect_valid with imem_ack in the same cycle: discard the data, pulse pf_flush, load fetch_pc=redirect_pc, set credits=DEPTH, go to ISSUE.
    - On redirect_valid without imem_ack: keep imem_req high (the bus cannot be cancelled), pulse pf_flush, load fetch_pc=redirect_pc, set credits=DEPTH-1, go to SQUASH.
  - SQUASH: imem_req stays high. On imem_ack, discard the data (no pf_push), drop imem_req, set credits=DEPTH and go to ISSUE. A further redirect_valid updates fetch_pc and pulses pf_flush again; the state stays SQUASH.
- pf_flush is registered, high for exactly one cycle per redirect cycle. pf_push is never asserted in the same cycle as pf_flush.
- Credit arithmetic:
  - credits_next = credits - issue + pop, where pop = pf_pop && !redirect_valid. A pop during a redirect cycle is ignored because the flush resets occupancy.
  - credits saturates at DEPTH; a pop at credits==DEPTH is ignored.
  - Issue is never allowed at credits==0.
- fetch_pc wraps modulo 2^32: 32'hFFFF_FFFC+4 = 0.
- Priority: rst > redirect_valid > imem_ack > issue.

Optional Feature:
FETCH_PERF_CNT_EN:
- Defined: perf_fetches increments on each pushed word; perf_squashes increments on each discarded ack; perf_stall_cycles increments each ISSUE/REQ cycle in which issue was blocked by stall or credits==0. All three wrap at 2^32 and clear on rst.
- Undefined: all three ports are tied to 0 and no counter logic is present.

Test Plan:
- Reset release, DEPTH=4, imem_ack same cycle as imem_req, no pops -> requests at 0x0, 0x4, 0x8, 0xC back-to-back. Four pf_push with matching pf_push_pc. credits reaches 0 and imem_req drops with fetch_pc=0x10.
- From the credits=0 state, pulse pf_pop once -> exactly one new request at 0x10; credits 0->1->0.
- Request at 0x8 with ack delayed 3 cycles, redirect_valid with redirect_pc=0x103 in the first wait cycle -> pf_flush pulses once. imem_req held until ack, data not pushed. Next request at 0x100; credits=DEPTH before that issue.
- redirect_valid and imem_ack in the same cycle -> no pf_push, pf_flush=1, next imem_addr=redirect target, no squash cycle.
- stall held 5 cycles in ISSUE with credits=4 -> imem_req stays 0. Request issues on the first cycle after stall falls. With FETCH_PERF_CNT_EN, perf_stall_cycles=5.
- fetch_pc=0xFFFF_FFFC, fetch acked -> next imem_addr=0x0000_0000. Assert rst mid-request -> imem_req=0, fetch_pc=RESET_PC in the same cycle.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC generation, imem handshake, prefetch push/flush and credit tracking.
// Optional performance counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4,
  parameter int          CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  input  logic          stall,
  input  logic          pf_pop,
  output logic          imem_req,
  output logic [31:0]   imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          pf_push,
  output logic [31:0]   pf_push_pc,
  output logic [31:0]   pf_push_data,
  output logic          pf_flush,
  output logic [31:0]   fetch_pc,
  output logic [CW-1:0] credits,
  output logic          fetch_busy,
  output logic [31:0]   perf_fetches,
  output logic [31:0]   perf_squashes,
  output logic [31:0]   perf_stall_cycles
);

  typedef enum logic [1:0] {IDLE, ISSUE, REQ, SQUASH} state_t;

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  state_t        state;
  logic          pop;
  logic [CW-1:0] credits_pop;
  logic [31:0]   redirect_target;
  logic [31:0]   pc_inc;

  // Pops during a redirect are dropped: the flush already empties the buffer.
  always_comb begin
    pop             = pf_pop && !redirect_valid;
    credits_pop     = (pop && (credits != FULL)) ? credits + CW'(1) : credits;
    redirect_target = {redirect_pc[31:2], 2'b00};
    pc_inc          = fetch_pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      imem_req     <= 1'b0;
      imem_addr    <= RESET_PC;
      pf_push      <= 1'b0;
      pf_push_pc   <= 32'h0;
      pf_push_data <= 32'h0;
      pf_flush     <= 1'b0;
      fetch_pc     <= RESET_PC;
      credits      <= FULL;
      fetch_busy   <= 1'b0;
    end else begin
      pf_push  <= 1'b0;
      pf_flush <= 1'b0;
      case (state)
        IDLE: state <= ISSUE;

        // Nothing is in flight here, so a flush frees every entry.
        ISSUE: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
            pf_flush <= 1'b1;
            credits  <= FULL;
          end else if ((credits != '0) && !stall) begin
            imem_req   <= 1'b1;
            fetch_busy <= 1'b1;
            imem_addr  <= fetch_pc;
            credits    <= credits_pop - CW'(1);
            state      <= REQ;
          end else begin
            credits <= credits_pop;
          end
        end

        REQ: begin
          if (redirect_valid) begin
            pf_flush <= 1'b1;
            fetch_pc <= redirect_target;
            if (imem_ack) begin
              imem_req   <= 1'b0;
              fetch_busy <= 1'b0;
              credits    <= FULL;
              state      <= ISSUE;
            end else begin
              // The outstanding bus request still owns one entry until it returns.
              credits <= FULL - CW'(1);
              state   <= SQUASH;
            end
          end else if (imem_ack) begin
            pf_push      <= 1'b1;
            pf_push_pc   <= imem_addr;
            pf_push_data <= imem_rdata;
            fetch_pc     <= pc_inc;
            if ((credits_pop != '0) && !stall) begin
              imem_addr <= pc_inc;
              credits   <= credits_pop - CW'(1);
            end else begin
              imem_req   <= 1'b0;
              fetch_busy <= 1'b0;
              credits    <= credits_pop;
              state      <= ISSUE;
            end
          end else begin
            credits <= credits_pop;
          end
        end

        SQUASH: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_target;
            pf_flush <= 1'b1;
          end
          if (imem_ack) begin
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            credits    <= FULL;
            state      <= ISSUE;
          end else begin
            credits <= credits_pop;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic ev_push;
  logic ev_squash;
  logic ev_stall;

  always_comb begin
    ev_push   = (state == REQ) && imem_ack && !redirect_valid;
    ev_squash = imem_ack && (((state == REQ) && redirect_valid) || (state == SQUASH));
    ev_stall  = !redirect_valid &&
                (((state == ISSUE) && (stall || (credits == '0))) ||
                 ((state == REQ) && imem_ack && (stall || (credits_pop == '0))));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetches      <= 32'h0;
      perf_squashes     <= 32'h0;
      perf_stall_cycles <= 32'h0;
    end else begin
      if (ev_push)   perf_fetches      <= perf_fetches + 32'd1;
      if (ev_squash) perf_squashes     <= perf_squashes + 32'd1;
      if (ev_stall)  perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`else
  assign perf_fetches      = 32'h0;
  assign perf_squashes     = 32'h0;
  assign perf_stall_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; memory returns addr ^ 0xC0DE0000.
module tb_fetch_sequencer;

  localparam int CW = 3;
  localparam logic [31:0] DMASK = 32'hC0DE_0000;

  logic          clk;
  logic          rst;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          stall;
  logic          pf_pop;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;
  logic          pf_push;
  logic [31:0]   pf_push_pc;
  logic [31:0]   pf_push_data;
  logic          pf_flush;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] credits;
  logic          fetch_busy;
  logic [31:0]   perf_fetches;
  logic [31:0]   perf_squashes;
  logic [31:0]   perf_stall_cycles;

  int checks;
  int failures;

  fetch_sequencer #(.RESET_PC(32'h0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall), .pf_pop(pf_pop),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .pf_push(pf_push), .pf_push_pc(pf_push_pc), .pf_push_data(pf_push_data),
    .pf_flush(pf_flush), .fetch_pc(fetch_pc), .credits(credits),
    .fetch_busy(fetch_busy),
    .perf_fetches(perf_fetches), .perf_squashes(perf_squashes),
    .perf_stall_cycles(perf_stall_cycles)
  );

  assign imem_rdata = DMASK ^ imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic st,
                               input logic pp, input logic ak);
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    pf_pop         = pp;
    imem_ack       = ak;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'h0; stall = 1'b0; pf_pop = 1'b0; imem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;

    // Reset state
    doReset();
    checkOutput("rst_req", imem_req, 0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_credits", credits, 4);
    checkOutput("rst_fetch_pc", fetch_pc, 32'h0);
    checkOutput("rst_push", pf_push, 0);
    checkOutput("rst_flush", pf_flush, 0);
    checkOutput("rst_busy", fetch_busy, 0);
    checkOutput("rst_perf_fetches", perf_fetches, 0);

    // Back-to-back fetches with immediate ack until credits run out
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("idle_no_req", imem_req, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("b2b_req0", imem_req, 1);
    checkOutput("b2b_addr0", imem_addr, 32'h0);
    checkOutput("b2b_cred0", credits, 3);
    checkOutput("b2b_busy0", fetch_busy, 1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(0, 0, 0, 0, 1);
      checkOutput("b2b_push", pf_push, 1);
      checkOutput("b2b_push_pc", pf_push_pc, 32'(4 * (i - 1)));
      checkOutput("b2b_push_data", pf_push_data, DMASK ^ 32'(4 * (i - 1)));
      checkOutput("b2b_addr", imem_addr, 32'(4 * i));
      checkOutput("b2b_cred", credits, 32'(3 - i));
    end
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("b2b_last_push_pc", pf_push_pc, 32'hC);
    checkOutput("b2b_last_push", pf_push, 1);
    checkOutput("b2b_drop_req", imem_req, 0);
    checkOutput("b2b_fetch_pc", fetch_pc, 32'h10);
    checkOutput("b2b_cred_zero", credits, 0);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_fetches4", perf_fetches, 4);
`endif
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("zero_cred_no_req", imem_req, 0);
    checkOutput("zero_cred_no_push", pf_push, 0);

    // One pop frees one credit -> exactly one request
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("pop_cred1", credits, 1);
    checkOutput("pop_no_req_yet", imem_req, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("pop_req", imem_req, 1);
    checkOutput("pop_addr", imem_addr, 32'h10);
    checkOutput("pop_cred0", credits, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("pop_push_pc", pf_push_pc, 32'h10);
    checkOutput("pop_drop_req", imem_req, 0);
    checkOutput("pop_fetch_pc", fetch_pc, 32'h14);

    // Redirect while a request is outstanding -> squash
    doReset();
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("sq_addr8", imem_addr, 32'h8);
    checkOutput("sq_push4", pf_push_pc, 32'h4);
    checkOutput("sq_cred1", credits, 1);
    applyStimulus(1, 32'h103, 0, 0, 0);
    checkOutput("sq_flush", pf_flush, 1);
    checkOutput("sq_req_held", imem_req, 1);
    checkOutput("sq_addr_held", imem_addr, 32'h8);
    checkOutput("sq_fetch_pc", fetch_pc, 32'h100);
    checkOutput("sq_cred3", credits, 3);
    checkOutput("sq_no_push", pf_push, 0);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("sq_flush_once", pf_flush, 0);
    checkOutput("sq_wait_req", imem_req, 1);
    checkOutput("sq_busy", fetch_busy, 1);
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("sq_ack_no_push", pf_push, 0);
    checkOutput("sq_ack_drop_req", imem_req, 0);
    checkOutput("sq_ack_cred4", credits, 4);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("sq_next_req", imem_req, 1);
    checkOutput("sq_next_addr", imem_addr, 32'h100);
    checkOutput("sq_next_cred", credits, 3);

    // Redirect coincident with ack -> no squash
    applyStimulus(1, 32'h2000, 0, 0, 1);
    checkOutput("ra_flush", pf_flush, 1);
    checkOutput("ra_no_push", pf_push, 0);
    checkOutput("ra_req_drop", imem_req, 0);
    checkOutput("ra_cred4", credits, 4);
    checkOutput("ra_fetch_pc", fetch_pc, 32'h2000);
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("ra_req", imem_req, 1);
    checkOutput("ra_addr", imem_addr, 32'h2000);
    checkOutput("ra_flush_clear", pf_flush, 0);

    // Stall held for 5 ISSUE cycles
    doReset();
    applyStimulus(0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("stall_no_req", imem_req, 0);
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("stall_release_req", imem_req, 1);
    checkOutput("stall_release_addr", imem_addr, 32'h0);
    checkOutput("stall_release_cred", credits, 3);
`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_stall5", perf_stall_cycles, 5);
`else
    checkOutput("perf_stall_tied", perf_stall_cycles, 0);
`endif

    // PC wrap and asynchronous reset mid-request
    doReset();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(1, 32'hFFFF_FFFF, 0, 0, 0);
    checkOutput("wrap_flush", pf_flush, 1);
    checkOutput("wrap_fetch_pc", fetch_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_no_req", imem_req, 0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap_push_pc", pf_push_pc, 32'hFFFF_FFFC);
    checkOutput("wrap_next_addr", imem_addr, 32'h0);
    checkOutput("wrap_next_fetch_pc", fetch_pc, 32'h0);
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("wrap_addr4", imem_addr, 32'h4);
    imem_ack = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("arst_req", imem_req, 0);
    checkOutput("arst_fetch_pc", fetch_pc, 32'h0);
    checkOutput("arst_addr", imem_addr, 32'h0);
    checkOutput("arst_credits", credits, 4);
    checkOutput("arst_push", pf_push, 0);
    checkOutput("arst_busy", fetch_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
